// File: rtl/rvv_vd_writeback_pkg.sv
// Shared types and constants for the vector destination write-back block.
package rvv_vd_writeback_pkg;

  localparam int LANE_FIELD_W = 64;
  localparam int REGI_W       = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } wb_state_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  function automatic logic [31:0] elem_bytes(input logic [2:0] vsew);
    return 32'd1 << vsew;
  endfunction

endpackage

// File: rtl/rvv_vd_writeback_if.sv
// Lane-result bus plus register-file write port of the write-back block.
interface rvv_vd_writeback_if #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
);
  import rvv_vd_writeback_pkg::*;

  localparam int NL = 1 << NB_LANES;

  logic                     start;
  logic [4:0]               vd_index;
  logic [VLEN-1:0]          old_vd;
  logic [2:0]               vsew;
  logic                     mask_dst;
  logic [LANE_FIELD_W*NL-1:0] lane_vd;
  logic [REGI_W*NL-1:0]     lane_regi;
  logic [NL-1:0]            lane_res;
  logic [3:0]               in_reg_offset;
  logic                     alu_done;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [4:0]               wr_index;
  logic [VLEN-1:0]          wr_data;
  logic [VLEN/8-1:0]        wr_be;
  logic                     busy;
  logic                     done;

  modport master (
    output start, vd_index, old_vd, vsew, mask_dst,
    output lane_vd, lane_regi, lane_res, in_reg_offset, alu_done, wr_ready,
    input  wr_valid, wr_index, wr_data, wr_be, busy, done
  );

  modport slave (
    input  start, vd_index, old_vd, vsew, mask_dst,
    input  lane_vd, lane_regi, lane_res, in_reg_offset, alu_done, wr_ready,
    output wr_valid, wr_index, wr_data, wr_be, busy, done
  );

endinterface

// File: rtl/rvv_vd_writeback_lane_merge.sv
// Turns one lane's beat into a VLEN-wide bit update mask, data and byte enables.
module rvv_wb_lane_merge
  import rvv_vd_writeback_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic                    lane_valid,
  input  logic [LANE_FIELD_W-1:0] lane_vd,
  input  logic [REGI_W-1:0]       lane_regi,
  input  logic [3:0]              in_reg_offset,
  input  logic [2:0]              vsew,
  input  logic                    mask_dst,
  output logic [VLEN-1:0]         upd_mask,
  output logic [VLEN-1:0]         upd_data,
  output logic [VLEN/8-1:0]       upd_be
);

  localparam int              VBYTES  = VLEN / 8;
  localparam logic [31:0]     CB      = 32'd1 << (LANE_WIDTH - 3);
  localparam logic [31:0]     LW      = 32'(LANE_WIDTH);
  localparam logic [VLEN-1:0] BIT_ONE = {{(VLEN-1){1'b0}}, 1'b1};
  localparam logic [VBYTES-1:0] BE_ONE = {{(VBYTES-1){1'b0}}, 1'b1};

  logic [31:0]       sew_w_s;
  logic [31:0]       elem_off_s;
  logic [31:0]       nbytes_s;
  logic [31:0]       addr_s;
  logic              fits_s;
  logic [VBYTES-1:0] byte_sel_s;

  // Byte address and size of this beat's chunk inside the register.
  always_comb begin
    sew_w_s = {29'd0, vsew} + 32'd3;
    if (sew_w_s <= LW) begin
      elem_off_s = 32'd0;
    end else begin
      elem_off_s = {28'd0, in_reg_offset} * CB;
    end
    if (sew_w_s < LW) begin
      nbytes_s = elem_bytes(vsew);
    end else begin
      nbytes_s = CB;
    end
    addr_s = (32'(lane_regi) << vsew) + elem_off_s;
    fits_s = (addr_s + nbytes_s) <= 32'(VBYTES);
  end

  // Out-of-register beats produce an empty update so they merge as a no-op.
  always_comb begin
    byte_sel_s = '0;
    upd_mask   = '0;
    upd_data   = '0;
    upd_be     = '0;
    if (lane_valid && mask_dst) begin
      if (32'(lane_regi) < 32'(VLEN)) begin
        upd_mask = BIT_ONE << lane_regi;
        upd_data = {{(VLEN-1){1'b0}}, lane_vd[0]} << lane_regi;
        upd_be   = BE_ONE << (lane_regi >> 3);
      end else begin
        upd_mask = '0;
      end
    end else if (lane_valid && fits_s) begin
      for (int b = 0; b < VBYTES; b++) begin
        byte_sel_s[b] = (32'(b) >= addr_s) && (32'(b) < (addr_s + nbytes_s));
      end
      for (int b = 0; b < VBYTES; b++) begin
        upd_mask[b*8 +: 8] = {8{byte_sel_s[b]}};
      end
      upd_be   = byte_sel_s;
      upd_data = (VLEN'(lane_vd) << {addr_s[28:0], 3'b000}) & upd_mask;
    end else begin
      upd_be = '0;
    end
  end

endmodule

// File: rtl/rvv_vd_writeback.sv
// Collects per-lane ALU beats into a copy of vd and issues one register-file write.
module rvv_vd_writeback
  import rvv_vd_writeback_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input logic             clk,
  input logic             resetn,
  rvv_vd_writeback_if.slave bus
);

  localparam int NL = 1 << NB_LANES;

  wb_state_e         state_q, state_d;
  logic [VLEN-1:0]   buf_q, buf_d;
  logic [VLEN/8-1:0] be_q, be_d;
  logic [4:0]        idx_q, idx_d;
  logic [2:0]        vsew_q, vsew_d;
  logic              mask_q, mask_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_valid_q, wr_valid_d;
  logic              collect_s;

  logic [VLEN-1:0]   lane_mask_s [NL];
  logic [VLEN-1:0]   lane_data_s [NL];
  logic [VLEN/8-1:0] lane_be_s   [NL];

  assign collect_s = (state_q == ST_COLLECT);

  for (genvar l = 0; l < NL; l++) begin : g_lane
    rvv_wb_lane_merge #(
      .VLEN       (VLEN),
      .LANE_WIDTH (LANE_WIDTH)
    ) u_merge (
      .lane_valid    (collect_s & bus.lane_res[l]),
      .lane_vd       (bus.lane_vd[l*LANE_FIELD_W +: LANE_FIELD_W]),
      .lane_regi     (bus.lane_regi[l*REGI_W +: REGI_W]),
      .in_reg_offset (bus.in_reg_offset),
      .vsew          (vsew_q),
      .mask_dst      (mask_q),
      .upd_mask      (lane_mask_s[l]),
      .upd_data      (lane_data_s[l]),
      .upd_be        (lane_be_s[l])
    );
  end

  // Next state, buffer merge and registered output values.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    be_d    = be_q;
    idx_d   = idx_q;
    vsew_d  = vsew_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          buf_d   = bus.old_vd;
          be_d    = '0;
          idx_d   = bus.vd_index;
          vsew_d  = bus.vsew;
          mask_d  = bus.mask_dst;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        // Lanes applied in ascending order so the higher lane wins a collision.
        for (int l = 0; l < NL; l++) begin
          buf_d = (buf_d & ~lane_mask_s[l]) | lane_data_s[l];
          be_d  = be_d | lane_be_s[l];
        end
        if (bus.alu_done) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (bus.wr_ready) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d     = (state_d == ST_COLLECT) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    wr_valid_d = (state_d == ST_WRITE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      be_q       <= '0;
      idx_q      <= 5'd0;
      vsew_q     <= 3'd0;
      mask_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      be_q       <= be_d;
      idx_q      <= idx_d;
      vsew_q     <= vsew_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_data  = buf_q;
  assign bus.wr_be    = be_q;
  assign bus.wr_index = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_rvv_vd_writeback.sv
// Randomized and directed bench for rvv_vd_writeback against a byte-level reference model.
module tb_rvv_vd_writeback;
  import rvv_vd_writeback_pkg::*;

  localparam int VLEN = 128;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rvv_vd_writeback_if #(.VLEN(VLEN), .NB_LANES(1)) bus ();

  rvv_vd_writeback #(.VLEN(VLEN), .LANE_WIDTH(3), .NB_LANES(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]  res;
    logic [63:0] vd0;
    logic [63:0] vd1;
    logic [16:0] r0;
    logic [16:0] r1;
    logic [3:0]  off;
  } beat_t;

  beat_t beats_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [127:0] o_data;
  logic [15:0]  o_be;
  logic [4:0]   o_idx;
  bit o_lat_ok, o_stable, o_done_pulse, o_idle_end, o_busy_start, o_timeout;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: one byte per element beat (8-bit lane chunk), one bit per mask beat.
  function automatic void model(input logic [127:0] old, input logic [2:0] vsew, input logic m,
                                output logic [127:0] d, output logic [15:0] be);
    longint r, addr;
    logic [63:0] v;
    d  = old;
    be = '0;
    foreach (beats_q[i]) begin
      for (int l = 0; l < 2; l++) begin
        if (beats_q[i].res[l]) begin
          v = (l == 1) ? beats_q[i].vd1 : beats_q[i].vd0;
          r = (l == 1) ? longint'(beats_q[i].r1) : longint'(beats_q[i].r0);
          if (m) begin
            if (r < 128) begin
              d[r]      = v[0];
              be[r / 8] = 1'b1;
            end
          end else begin
            addr = r * (longint'(1) << vsew) + ((vsew == 3'd0) ? 0 : longint'(beats_q[i].off));
            if (addr < 16) begin
              d[addr*8 +: 8] = v[7:0];
              be[addr]       = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.vd_index = 5'd0; bus.old_vd = '0; bus.vsew = 3'd0; bus.mask_dst = 1'b0;
    bus.lane_vd = '0; bus.lane_regi = '0; bus.lane_res = 2'b00; bus.in_reg_offset = 4'd0;
    bus.alu_done = 1'b0; bus.wr_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_beat(input beat_t b);
    bus.lane_res      = b.res;
    bus.lane_vd       = {b.vd1, b.vd0};
    bus.lane_regi     = {b.r1, b.r0};
    bus.in_reg_offset = b.off;
  endtask

  task automatic run_txn(input logic [127:0] old, input logic [4:0] idx, input logic [2:0] vsew,
                         input logic m, input bit done_on_last, input int ready_delay);
    int w;
    o_timeout = 0; o_stable = 1; o_done_pulse = 0; o_idle_end = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.old_vd = old; bus.vd_index = idx; bus.vsew = vsew; bus.mask_dst = m;
    @(negedge clk);
    bus.start = 1'b0; bus.old_vd = ~old; bus.vd_index = ~idx; bus.vsew = ~vsew; bus.mask_dst = ~m;
    o_busy_start = bus.busy;
    for (int i = 0; i < beats_q.size(); i++) begin
      drive_beat(beats_q[i]);
      bus.alu_done = done_on_last && (i == beats_q.size() - 1);
      @(negedge clk);
    end
    bus.lane_res = 2'b00;
    if (!(done_on_last && beats_q.size() > 0)) begin
      bus.alu_done = 1'b1;
      @(negedge clk);
    end
    bus.alu_done = 1'b0;
    o_lat_ok = bus.wr_valid;
    w = 0;
    while (!bus.wr_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.wr_valid) begin
      o_timeout = 1;
      return;
    end
    o_data = bus.wr_data; o_be = bus.wr_be; o_idx = bus.wr_index;
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk);
      if (!bus.wr_valid || bus.wr_data !== o_data || bus.wr_be !== o_be || bus.wr_index !== o_idx)
        o_stable = 0;
    end
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.wr_ready = 1'b0;
    o_done_pulse = bus.done && !bus.wr_valid;
    @(negedge clk);
    o_idle_end = !bus.done && !bus.busy;
  endtask

  function automatic beat_t mk(input logic [1:0] res, input logic [63:0] v0, input logic [63:0] v1,
                               input logic [16:0] r0, input logic [16:0] r1, input logic [3:0] off);
    beat_t b;
    b.res = res; b.vd0 = v0; b.vd1 = v1; b.r0 = r0; b.r1 = r1; b.off = off;
    return b;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #1;
    n_vec++;
    if ({bus.wr_valid, bus.busy, bus.done} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000", {bus.wr_valid, bus.busy, bus.done});
    end
    n_vec++;
    if (bus.wr_data !== '0 || bus.wr_be !== '0 || bus.wr_index !== 5'd0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h want zeros", bus.wr_data, bus.wr_be, bus.wr_index);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_elem_bytes();
    logic [127:0] old, ed; logic [15:0] eb;
    do_reset();
    old = {$urandom, $urandom, $urandom, $urandom};
    beats_q = {};
    beats_q.push_back(mk(2'b11, 64'hAA, 64'hBB, 17'd0, 17'd1, 4'd0));
    beats_q.push_back(mk(2'b11, 64'hCC, 64'hDD, 17'd2, 17'd3, 4'd0));
    run_txn(old, 5'd7, 3'd0, 1'b0, 1'b1, 0);
    ed = {old[127:32], 32'hDDCCBBAA};
    n_vec++;
    if (o_timeout || o_data !== ed) begin n_err++; $display("FAIL elem_data: got %h want %h", o_data, ed); end
    n_vec++;
    if (o_be !== 16'h000F) begin n_err++; $display("FAIL elem_be: got %h want 000f", o_be); end
    n_vec++;
    if (o_idx !== 5'd7) begin n_err++; $display("FAIL elem_idx: got %0d want 7", o_idx); end
    n_vec++;
    if (!o_lat_ok || !o_busy_start) begin n_err++; $display("FAIL elem_latency: valid %b busy %b want 1 1", o_lat_ok, o_busy_start); end
    model(old, 3'd0, 1'b0, ed, eb);
    n_vec++;
    if (o_data !== ed || o_be !== eb) begin n_err++; $display("FAIL elem_model: got %h want %h", o_data, ed); end
  endtask

  task automatic test_wide_chunks();
    logic [127:0] old;
    logic [7:0] bv [4];
    bv[0] = 8'h11; bv[1] = 8'h22; bv[2] = 8'h33; bv[3] = 8'h44;
    do_reset();
    old = {$urandom, $urandom, $urandom, $urandom};
    beats_q = {};
    for (int k = 0; k < 4; k++) beats_q.push_back(mk(2'b01, {56'd0, bv[k]}, 64'd0, 17'd1, 17'd0, 4'(k)));
    run_txn(old, 5'd3, 3'd2, 1'b0, 1'b0, 1);
    n_vec++;
    if (o_timeout || o_data[63:32] !== 32'h44332211 || o_data[31:0] !== old[31:0] || o_data[127:64] !== old[127:64]) begin
      n_err++; $display("FAIL wide_data: got %h want %h_44332211_%h", o_data, old[127:64], old[31:0]);
    end
    n_vec++;
    if (o_be !== 16'h00F0) begin n_err++; $display("FAIL wide_be: got %h want 00f0", o_be); end
  endtask

  task automatic test_mask();
    beats_q = {};
    do_reset();
    for (int k = 0; k < 8; k++) beats_q.push_back(mk(2'b11, 64'd1, 64'd0, 17'(2*k), 17'(2*k+1), 4'd0));
    run_txn({128{1'b1}}, 5'd1, 3'd1, 1'b1, 1'b1, 0);
    n_vec++;
    if (o_timeout || o_data !== {{112{1'b1}}, 16'h5555}) begin
      n_err++; $display("FAIL mask_data: got %h want ffff..5555", o_data);
    end
    n_vec++;
    if (o_be !== 16'h0003) begin n_err++; $display("FAIL mask_be: got %h want 0003", o_be); end
  endtask

  task automatic test_out_of_range();
    logic [127:0] old;
    do_reset();
    old = {$urandom, $urandom, $urandom, $urandom};
    beats_q = {};
    beats_q.push_back(mk(2'b01, 64'h5A, 64'd0, 17'd20, 17'd0, 4'd0));
    run_txn(old, 5'd9, 3'd3, 1'b0, 1'b1, 0);
    n_vec++;
    if (o_timeout || o_data !== old || o_be !== 16'h0000) begin
      n_err++; $display("FAIL oor_drop: got %h/%h want %h/0000", o_data, o_be, old);
    end
    beats_q = {};
    run_txn(old, 5'd2, 3'd0, 1'b0, 1'b0, 0);
    n_vec++;
    if (o_timeout || o_data !== old || o_be !== 16'h0000 || !o_lat_ok || !o_done_pulse) begin
      n_err++; $display("FAIL zero_beats: got %h/%h lat %b done %b want %h/0000 1 1", o_data, o_be, o_lat_ok, o_done_pulse, old);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] old, ed; logic [15:0] eb;
    do_reset();
    old = {$urandom, $urandom, $urandom, $urandom};
    beats_q = {};
    beats_q.push_back(mk(2'b11, 64'h12, 64'h34, 17'd5, 17'd9, 4'd0));
    run_txn(old, 5'd30, 3'd0, 1'b0, 1'b0, 5);
    model(old, 3'd0, 1'b0, ed, eb);
    n_vec++;
    if (o_timeout || !o_stable) begin n_err++; $display("FAIL bp_stable: stable %b want 1", o_stable); end
    n_vec++;
    if (!o_done_pulse || !o_idle_end) begin n_err++; $display("FAIL bp_done: pulse %b end %b want 1 1", o_done_pulse, o_idle_end); end
    n_vec++;
    if (o_data !== ed || o_be !== eb) begin n_err++; $display("FAIL bp_data: got %h/%h want %h/%h", o_data, o_be, ed, eb); end
  endtask

  task automatic test_ignored();
    logic [127:0] a, ed; logic [15:0] eb; logic [127:0] snap;
    do_reset();
    @(negedge clk);
    drive_beat(mk(2'b11, 64'hFF, 64'hEE, 17'd0, 17'd1, 4'd0));
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.lane_res = 2'b00; bus.alu_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.wr_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_beats: busy %b valid %b want 0 0", bus.busy, bus.wr_valid);
    end
    a = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1; bus.old_vd = a; bus.vd_index = 5'd5; bus.vsew = 3'd0; bus.mask_dst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.old_vd = ~a; bus.vd_index = 5'd9; bus.vsew = 3'd1; bus.mask_dst = 1'b1;
    drive_beat(mk(2'b01, 64'h5A, 64'd0, 17'd3, 17'd0, 4'd0));
    @(negedge clk);
    bus.start = 1'b0; bus.lane_res = 2'b00; bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    snap = bus.wr_data;
    drive_beat(mk(2'b11, 64'h77, 64'h66, 17'd4, 17'd5, 4'd0));
    repeat (2) @(negedge clk);
    bus.lane_res = 2'b00;
    beats_q = {};
    beats_q.push_back(mk(2'b01, 64'h5A, 64'd0, 17'd3, 17'd0, 4'd0));
    model(a, 3'd0, 1'b0, ed, eb);
    n_vec++;
    if (bus.wr_valid !== 1'b1 || bus.wr_data !== ed || snap !== ed || bus.wr_be !== eb || bus.wr_index !== 5'd5) begin
      n_err++; $display("FAIL busy_start: got %h/%h idx %0d want %h/%h idx 5", bus.wr_data, bus.wr_be, bus.wr_index, ed, eb);
    end
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.wr_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] old, ed; logic [15:0] eb;
    bit seen;
    do_reset();
    old = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1; bus.old_vd = old; bus.vd_index = 5'd11;
    @(negedge clk);
    bus.start = 1'b0;
    drive_beat(mk(2'b11, 64'h01, 64'h02, 17'd0, 17'd1, 4'd0));
    @(negedge clk);
    bus.lane_res = 2'b00;
    resetn = 1'b0;
    #1;
    n_vec++;
    if ({bus.wr_valid, bus.busy, bus.done} !== 3'b000 || bus.wr_data !== '0 || bus.wr_be !== '0 || bus.wr_index !== 5'd0) begin
      n_err++; $display("FAIL reset_collect: ctrl %b data %h be %h", {bus.wr_valid, bus.busy, bus.done}, bus.wr_data, bus.wr_be);
    end
    @(negedge clk);
    bus.alu_done = 1'b1;
    resetn = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.wr_valid || bus.done || bus.busy) seen = 1;
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL reset_abandon: activity %b want 0", seen); end
    beats_q = {};
    beats_q.push_back(mk(2'b10, 64'd0, 64'h9C, 17'd0, 17'd6, 4'd0));
    run_txn(old, 5'd4, 3'd0, 1'b0, 1'b1, 1);
    model(old, 3'd0, 1'b0, ed, eb);
    n_vec++;
    if (o_timeout || o_data !== ed || o_be !== eb) begin
      n_err++; $display("FAIL reset_fresh: got %h/%h want %h/%h", o_data, o_be, ed, eb);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.old_vd = old;
    @(negedge clk);
    bus.start = 1'b0; bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (bus.wr_valid !== 1'b0 || bus.wr_be !== '0) begin
      n_err++; $display("FAIL reset_write: valid %b be %h want 0 0", bus.wr_valid, bus.wr_be);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0] old, ed; logic [15:0] eb;
    logic [2:0] vsew; logic m; logic [4:0] idx;
    int nb, lim;
    beat_t b;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      old  = {$urandom, $urandom, $urandom, $urandom};
      vsew = 3'($urandom_range(0, 3));
      m    = ($urandom_range(0, 3) == 0);
      idx  = 5'($urandom);
      nb   = $urandom_range(0, 6);
      lim  = (16 >> vsew) + 2;
      beats_q = {};
      for (int i = 0; i < nb; i++) begin
        b.res = 2'($urandom);
        b.vd0 = {$urandom, $urandom};
        b.vd1 = {$urandom, $urandom};
        b.r0  = m ? 17'($urandom_range(0, 140)) : 17'($urandom_range(0, lim));
        b.r1  = ($urandom_range(0, 3) == 0) ? b.r0 :
                (m ? 17'($urandom_range(0, 140)) : 17'($urandom_range(0, lim)));
        if ($urandom_range(0, 15) == 0) b.r1 = 17'h1FFFF;
        b.off = (vsew == 3'd0) ? 4'($urandom) : 4'($urandom_range(0, (1 << vsew) - 1));
        beats_q.push_back(b);
      end
      run_txn(old, idx, vsew, m, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      model(old, vsew, m, ed, eb);
      n_vec++;
      if (o_timeout || o_data !== ed) begin
        n_err++; $display("FAIL rnd_data t%0d: got %h want %h", t, o_data, ed);
      end
      n_vec++;
      if (o_be !== eb || o_idx !== idx) begin
        n_err++; $display("FAIL rnd_be t%0d: got %h idx %0d want %h idx %0d", t, o_be, o_idx, eb, idx);
      end
      n_vec++;
      if (!o_lat_ok || !o_stable || !o_done_pulse || !o_idle_end || !o_busy_start) begin
        n_err++; $display("FAIL rnd_proto t%0d: lat %b stable %b done %b end %b busy %b want 11111",
                          t, o_lat_ok, o_stable, o_done_pulse, o_idle_end, o_busy_start);
      end
      if (o_timeout) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_elem_bytes();
    test_wide_chunks();
    test_mask();
    test_out_of_range();
    test_backpressure();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
